// File: rtl/stack_guard_ctrl.sv
// stack_guard_ctrl: protected-stack-address buffer sequencer.
// Records sp/fp store addresses, prunes them on return and scans one entry per
// cycle on a check; a hit raises a held crash request until acknowledged.
// Build option: define STACK_GUARD_STICKY_CRASH_EN to make the crash state
// terminal until reset (crash_ack_i is then ignored).
module stack_guard_ctrl #(
  parameter int unsigned DEPTH  = 6,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic                         flush_i,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  input  logic [ADDR_W-1:0]            wr_addr_i,
  input  logic                         chk_valid_i,
  output logic                         chk_ready_o,
  input  logic [ADDR_W-1:0]            chk_addr_i,
  output logic                         chk_done_o,
  output logic                         chk_hit_o,
  input  logic                         ret_valid_i,
  output logic                         ret_ready_o,
  input  logic [ADDR_W-1:0]            ret_sp_i,
  output logic                         crash_o,
  input  logic                         crash_ack_i,
  output logic [ADDR_W-1:0]            crash_addr_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OccW = $clog2(DEPTH + 1);

`ifdef STACK_GUARD_STICKY_CRASH_EN
  localparam bit Sticky = 1'b1;
`else
  localparam bit Sticky = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StScan, StAlarm} state_e;

  state_e              state_q;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q [DEPTH];
  logic [IdxW-1:0]     wr_ptr_q, idx_q;
  logic [ADDR_W-1:0]   chk_addr_q, crash_addr_q;
  logic                chk_done_q, chk_hit_q, crash_q;
  logic [OccW-1:0]     occ_q, occ_d;
  logic                ret_hs, chk_hs, wr_hs, scan_hit;

  // Fixed-priority arbitration ret > chk > wr, only while idle.
  always_comb begin
    ret_ready_o = (state_q == StIdle);
    chk_ready_o = (state_q == StIdle) && !ret_valid_i;
    wr_ready_o  = (state_q == StIdle) && !ret_valid_i && !chk_valid_i;
    ret_hs      = ret_valid_i && ret_ready_o;
    chk_hs      = chk_valid_i && chk_ready_o;
    wr_hs       = wr_valid_i && wr_ready_o;
    scan_hit    = valid_q[idx_q] && (addr_q[idx_q] == chk_addr_q);
  end

  // Next valid vector and its population count, so occupancy tracks the same edge.
  always_comb begin
    valid_d = valid_q;
    if (ret_hs) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q[i] < ret_sp_i) valid_d[i] = 1'b0;
      end
    end else if (wr_hs && en_i) begin
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (state_q == StAlarm && crash_ack_i && !Sticky) valid_d = '0;
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OccW'(valid_d[i]);
    end
  end

  // Control FSM with storage and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      wr_ptr_q     <= '0;
      idx_q        <= '0;
      chk_addr_q   <= '0;
      crash_addr_q <= '0;
      chk_done_q   <= 1'b0;
      chk_hit_q    <= 1'b0;
      crash_q      <= 1'b0;
      occ_q        <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      chk_done_q <= 1'b0;
      chk_hit_q  <= 1'b0;
      valid_q    <= valid_d;
      occ_q      <= occ_d;
      case (state_q)
        StIdle: begin
          if (ret_hs) begin
            // Pruning is fully handled by valid_d.
          end else if (chk_hs) begin
            if (en_i) begin
              chk_addr_q <= chk_addr_i;
              idx_q      <= '0;
              state_q    <= StScan;
            end else begin
              chk_done_q <= 1'b1;  // disabled guard: immediate miss
            end
          end else if (wr_hs && en_i) begin
            addr_q[wr_ptr_q] <= wr_addr_i;
            wr_ptr_q <= (wr_ptr_q == IdxW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
          end
        end
        StScan: begin
          if (flush_i) begin
            state_q <= StIdle;
          end else if (scan_hit) begin
            state_q      <= StAlarm;
            chk_done_q   <= 1'b1;
            chk_hit_q    <= 1'b1;
            crash_q      <= 1'b1;
            crash_addr_q <= chk_addr_q;
          end else if (idx_q == IdxW'(DEPTH - 1)) begin
            state_q    <= StIdle;
            chk_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StAlarm: begin
          if (crash_ack_i && !Sticky) begin
            state_q      <= StIdle;
            crash_q      <= 1'b0;
            crash_addr_q <= '0;
            wr_ptr_q     <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign chk_done_o   = chk_done_q;
  assign chk_hit_o    = chk_hit_q;
  assign crash_o      = crash_q;
  assign crash_addr_o = crash_addr_q;
  assign occupancy_o  = occ_q;

endmodule

// File: doc/stack_guard_ctrl.md
# stack_guard_ctrl

Sequencer for the protected-stack-address buffer that feeds the crash path of the branch unit. It records the effective addresses of sp/fp-based stores and checks non-sp/fp stores against them by scanning one entry per cycle. It prunes entries that drop out of scope on function return. On a hit it raises a held crash request towards the resolve logic until that request is acknowledged.

## Interface
- DEPTH, 6, number of tracked addresses (≥2)
- ADDR_W, 32, address width
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- en_i  in  1  guard enable (driven high only at user privilege); when low, wr/chk handshakes complete with no effect
- flush_i  in  1  pipeline flush
- wr_valid_i / wr_ready_o  in/out  1  record request handshake
- wr_addr_i  in  ADDR_W  address to record
- chk_valid_i / chk_ready_o  in/out  1  check request handshake
- chk_addr_i  in  ADDR_W  address to check
- chk_done_o  out  1  one-cycle pulse: check finished
- chk_hit_o  out  1  qualifies chk_done_o: address was found
- ret_valid_i / ret_ready_o  in/out  1  prune request handshake
- ret_sp_i  in  ADDR_W  stack pointer after return
- crash_o  out  1  crash request, level
- crash_ack_i  in  1  crash consumed by resolve logic
- crash_addr_o  out  ADDR_W  offending check address
- occupancy_o  out  $clog2(DEPTH+1)  number of valid entries

## Operation
- Storage: DEPTH × {valid, addr}, plus wr_ptr in 0..DEPTH-1.
- FSM states: IDLE, SCAN, ALARM.
- IDLE arbitration, in priority order ret > chk > wr. Only the highest-priority valid request is ready. Concretely: ret_ready_o=1; chk_ready_o=!ret_valid_i; wr_ready_o=!ret_valid_i&&!chk_valid_i. All ready outputs are 0 outside IDLE.
- Record: on handshake with en_i=1, entry[wr_ptr] is set to {1, wr_addr_i}. wr_ptr then advances modulo DEPTH.
  - When the buffer is full, the write overwrites the oldest slot; occupancy stays at DEPTH.
  - Duplicate addresses are permitted.
- Prune: on handshake, every valid entry with addr < ret_sp_i (unsigned compare) is cleared in a single cycle. wr_ptr is unchanged; holes are not compacted.
- Check: on handshake with en_i=1, the FSM latches chk_addr_i, sets idx=0 and enters SCAN. With en_i=0, the FSM stays in IDLE and chk_done_o pulses with hit=0 in the next cycle.
- SCAN: each cycle compares entry[idx] (valid && addr==latched address).
  - Hit: go to ALARM; pulse chk_done_o with chk_hit_o=1.
  - Miss at idx=DEPTH-1: go to IDLE; pulse chk_done_o with chk_hit_o=0.
  - Otherwise: idx++.
- flush_i in SCAN: abort to IDLE with no done pulse. flush_i is ignored in IDLE (a same-cycle handshake still proceeds) and in ALARM.
- ALARM: crash_o=1 and crash_addr_o=latched address, held until crash_ack_i=1. In the ack cycle the FSM goes to IDLE and all entries are cleared; wr_ptr resets to 0.
- occupancy_o is a registered count of valid entries, updated in the same edge as the write, prune or clear that changes it.

## Timing
- Reset values:
  - state=IDLE; all entries invalid; wr_ptr=0.
  - crash_o=0, crash_addr_o=0, chk_done_o=0, chk_hit_o=0, occupancy_o=0.
  - ready outputs follow IDLE rules from the first cycle after reset.
- Record visibility: an entry written at edge T is visible to a scan starting at T+1.
- Check latency, with handshake at edge T:
  - entry i is compared in cycle T+1+i;
  - a hit at i gives done/hit registered at edge T+2+i, together with crash_o=1;
  - a miss gives done at edge T+1+DEPTH.
- crash_o falls at the edge following the cycle in which crash_ack_i is high. crash_ack_i is ignored when crash_o=0.
- Reset asserted mid-scan or in ALARM: immediate return to reset values, with no done pulse.

## Configuration
- STACK_GUARD_STICKY_CRASH_EN:
  - Defined: ALARM is terminal. crash_o stays 1 and all ready outputs stay 0 until reset; crash_ack_i is ignored.
  - Undefined: ALARM exits on ack as described above.

## Test plan
- DEPTH=6, record 0x80001000, then check 0x80001000 at T → compare at T+1 hits; chk_done_o=chk_hit_o=1 and crash_o=1 at T+2; crash_addr_o=0x80001000; ack → IDLE, occupancy_o=0.
- Record 7 addresses A0..A6, then check A0 → miss, done at T+7 with hit=0; occupancy_o=6; A6 is in slot 0.
- Record 0x80000F00 and 0x80001100; ret with sp=0x80001000 → occupancy 2→1; check 0x80000F00 misses; check 0x80001100 hits.
- Assert ret, chk and wr valid together in IDLE → only ret_ready_o=1. Next cycle, with ret dropped: chk_ready_o=1, wr_ready_o=0.
- flush_i at scan cycle 3 → IDLE with no done pulse; a following check completes normally.
- With the macro defined: hit, then crash_ack_i=1 → crash_o stays 1 and ready outputs stay 0 until rst_ni is asserted.
